// File: rtl/reg_port_ctrl.sv
// Register-file port sequencer: queues writeback writes, serves decode reads with
// forwarding from the queue, and arbitrates the single we/re file port.
module reg_port_ctrl #(
  parameter int WQ_DEPTH = 4,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       wr_valid_i,
  output logic                       wr_ready_o,
  input  logic [ADDR_W-1:0]          wr_addr_i,
  input  logic [DATA_W-1:0]          wr_data_i,
  input  logic                       rd_valid_i,
  output logic                       rd_ready_o,
  input  logic [ADDR_W-1:0]          rd_addr_a_i,
  input  logic [ADDR_W-1:0]          rd_addr_b_i,
  output logic                       rsp_valid_o,
  output logic [DATA_W-1:0]          rsp_data_a_o,
  output logic [DATA_W-1:0]          rsp_data_b_o,
  output logic [$clog2(WQ_DEPTH):0]  wq_count_o,
  output logic [ADDR_W-1:0]          rf_reg_a_o,
  output logic [ADDR_W-1:0]          rf_reg_b_o,
  output logic [ADDR_W-1:0]          rf_reg_w_o,
  output logic [DATA_W-1:0]          rf_data_in_o,
  output logic                       rf_we_o,
  output logic                       rf_re_o,
  input  logic [DATA_W-1:0]          rf_out_a_i,
  input  logic [DATA_W-1:0]          rf_out_b_i
);

  localparam int PW = $clog2(WQ_DEPTH);

  logic [PW:0]         head_q, head_d, tail_q, tail_d;
  logic [PW:0]         count;
  logic                full;
  logic                rd_acc, enq, deq;
  logic [ADDR_W-1:0]   wq_addr_q [WQ_DEPTH];
  logic [DATA_W-1:0]   wq_data_q [WQ_DEPTH];

  logic                fwd_a_hit, fwd_b_hit;
  logic [DATA_W-1:0]   fwd_a_data, fwd_b_data;

  logic                rsp_valid_q, rsp_valid_d;
  logic                zero_a_q, zero_a_d, zero_b_q, zero_b_d;
  logic                fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
  logic [DATA_W-1:0]   fwd_data_a_q, fwd_data_a_d, fwd_data_b_q, fwd_data_b_d;

  // Wrap bit in the pointers lets full and empty be told apart by subtraction.
  assign count      = tail_q - head_q;
  assign full       = (count == (PW+1)'(WQ_DEPTH));
  assign wq_count_o = count;

  assign wr_ready_o = !full && !rst_i;
  assign rd_ready_o = !full && !rst_i;

  assign rd_acc = rd_valid_i && rd_ready_o;
  assign enq    = wr_valid_i && wr_ready_o && (wr_addr_i != '0);
  assign deq    = rf_we_o;

  always_comb begin
    rf_we_o = 1'b0;
    rf_re_o = 1'b0;
    if (!rst_i) begin
      if (full) begin
        rf_we_o = 1'b1;
      end else if (rd_valid_i) begin
        rf_re_o = 1'b1;
      end else if (count != '0) begin
        rf_we_o = 1'b1;
      end
    end
  end

  assign rf_reg_a_o   = rd_addr_a_i;
  assign rf_reg_b_o   = rd_addr_b_i;
  assign rf_reg_w_o   = wq_addr_q[head_q[PW-1:0]];
  assign rf_data_in_o = wq_data_q[head_q[PW-1:0]];

  assign head_d = head_q + (PW+1)'(deq);
  assign tail_d = tail_q + (PW+1)'(enq);

  // Walk oldest to youngest so the last match (youngest write) wins.
  always_comb begin
    logic [PW-1:0] idx;
    idx        = '0;
    fwd_a_hit  = 1'b0;
    fwd_b_hit  = 1'b0;
    fwd_a_data = '0;
    fwd_b_data = '0;
    for (int i = 0; i < WQ_DEPTH; i++) begin
      idx = head_q[PW-1:0] + PW'(i);
      if ((PW+1)'(i) < count) begin
        if (wq_addr_q[idx] == rd_addr_a_i) begin
          fwd_a_hit  = 1'b1;
          fwd_a_data = wq_data_q[idx];
        end
        if (wq_addr_q[idx] == rd_addr_b_i) begin
          fwd_b_hit  = 1'b1;
          fwd_b_data = wq_data_q[idx];
        end
      end
    end
  end

  assign rsp_valid_d  = rd_acc;
  assign zero_a_d     = rd_acc ? (rd_addr_a_i == '0) : zero_a_q;
  assign zero_b_d     = rd_acc ? (rd_addr_b_i == '0) : zero_b_q;
  assign fwd_a_d      = rd_acc ? fwd_a_hit : fwd_a_q;
  assign fwd_b_d      = rd_acc ? fwd_b_hit : fwd_b_q;
  assign fwd_data_a_d = rd_acc ? fwd_a_data : fwd_data_a_q;
  assign fwd_data_b_d = rd_acc ? fwd_b_data : fwd_data_b_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      head_q       <= '0;
      tail_q       <= '0;
      rsp_valid_q  <= 1'b0;
      zero_a_q     <= 1'b0;
      zero_b_q     <= 1'b0;
      fwd_a_q      <= 1'b0;
      fwd_b_q      <= 1'b0;
      fwd_data_a_q <= '0;
      fwd_data_b_q <= '0;
    end else begin
      head_q       <= head_d;
      tail_q       <= tail_d;
      rsp_valid_q  <= rsp_valid_d;
      zero_a_q     <= zero_a_d;
      zero_b_q     <= zero_b_d;
      fwd_a_q      <= fwd_a_d;
      fwd_b_q      <= fwd_b_d;
      fwd_data_a_q <= fwd_data_a_d;
      fwd_data_b_q <= fwd_data_b_d;
    end
  end

  // Entry storage needs no reset: only slots between head and tail are ever read.
  always_ff @(posedge clk_i) begin
    if (enq) begin
      wq_addr_q[tail_q[PW-1:0]] <= wr_addr_i;
      wq_data_q[tail_q[PW-1:0]] <= wr_data_i;
    end
  end

  // The file is not written while a read is accepted, so rf_out reflects pre-read state.
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_data_a_o = zero_a_q ? '0 : (fwd_a_q ? fwd_data_a_q : rf_out_a_i);
  assign rsp_data_b_o = zero_b_q ? '0 : (fwd_b_q ? fwd_data_b_q : rf_out_b_i);

endmodule

// File: tb/tb_reg_port_ctrl.sv
// Self-checking bench for reg_port_ctrl: register-file model on the file port and
// a queue-level reference model of architectural register state.
module tb_reg_port_ctrl;
  localparam int D  = 4;
  localparam int AW = 5;
  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          wr_valid, wr_ready, rd_valid, rd_ready;
  logic [AW-1:0] wr_addr, rd_addr_a, rd_addr_b;
  logic [DW-1:0] wr_data;
  logic          rsp_valid;
  logic [DW-1:0] rsp_data_a, rsp_data_b;
  logic [2:0]    wq_count;
  logic [AW-1:0] rf_reg_a, rf_reg_b, rf_reg_w;
  logic [DW-1:0] rf_data_in, rf_out_a, rf_out_b;
  logic          rf_we, rf_re;

  reg_port_ctrl #(.WQ_DEPTH(D), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk_i(clk), .rst_i(rst),
    .wr_valid_i(wr_valid), .wr_ready_o(wr_ready), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .rd_valid_i(rd_valid), .rd_ready_o(rd_ready), .rd_addr_a_i(rd_addr_a), .rd_addr_b_i(rd_addr_b),
    .rsp_valid_o(rsp_valid), .rsp_data_a_o(rsp_data_a), .rsp_data_b_o(rsp_data_b),
    .wq_count_o(wq_count),
    .rf_reg_a_o(rf_reg_a), .rf_reg_b_o(rf_reg_b), .rf_reg_w_o(rf_reg_w),
    .rf_data_in_o(rf_data_in), .rf_we_o(rf_we), .rf_re_o(rf_re),
    .rf_out_a_i(rf_out_a), .rf_out_b_i(rf_out_b)
  );

  // Register file behaviour seen through its port
  logic [DW-1:0] rf_mem [32] = '{default: '0};
  logic [AW-1:0] lat_a = '0, lat_b = '0;
  always @(posedge clk) begin
    if (rf_we) begin
      if (rf_reg_w != '0) rf_mem[rf_reg_w] <= rf_data_in;
    end else if (rf_re) begin
      lat_a <= rf_reg_a;
      lat_b <= rf_reg_b;
    end
  end
  assign rf_out_a = rf_mem[lat_a];
  assign rf_out_b = rf_mem[lat_b];

  // Reference model: committed file contents plus an ordered list of pending writes
  typedef struct packed { logic [AW-1:0] a; logic [DW-1:0] d; } ent_t;
  ent_t          mq[$];
  logic [DW-1:0] file_m [32] = '{default: '0};
  bit            pend;
  logic [DW-1:0] pa, pb;

  int n_chk  = 0;
  int n_fail = 0;

  function automatic logic [DW-1:0] view(input logic [AW-1:0] a);
    logic [DW-1:0] v;
    if (a == '0) return '0;
    v = file_m[a];
    foreach (mq[i]) if (mq[i].a == a) v = mq[i].d;
    return v;
  endfunction

  function automatic bit m_full();  return mq.size() == D; endfunction
  function automatic bit e_ready(); return !rst && !m_full(); endfunction
  function automatic bit e_we();    return !rst && (m_full() || (!rd_valid && mq.size() > 0)); endfunction
  function automatic bit e_re();    return !rst && !m_full() && rd_valid; endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    pend = 1'b0;
  endtask

  task automatic compare_model();
    chk("wr_ready", 64'(wr_ready), 64'(e_ready()));
    chk("rd_ready", 64'(rd_ready), 64'(e_ready()));
    chk("rf_we", 64'(rf_we), 64'(e_we()));
    chk("rf_re", 64'(rf_re), 64'(e_re()));
    chk("wq_count", 64'(wq_count), 64'(mq.size()));
    chk("rsp_valid", 64'(rsp_valid), 64'(pend));
    if (e_we()) begin
      chk("rf_reg_w", 64'(rf_reg_w), 64'(mq[0].a));
      chk("rf_data_in", 64'(rf_data_in), 64'(mq[0].d));
    end
    if (e_re()) begin
      chk("rf_reg_a", 64'(rf_reg_a), 64'(rd_addr_a));
      chk("rf_reg_b", 64'(rf_reg_b), 64'(rd_addr_b));
    end
    if (pend) begin
      chk("rsp_data_a", 64'(rsp_data_a), 64'(pa));
      chk("rsp_data_b", 64'(rsp_data_b), 64'(pb));
    end
  endtask

  task automatic model_tick();
    bit   we, re, rdy;
    ent_t e;
    if (rst) begin
      model_reset();
    end else begin
      we  = e_we();
      re  = e_re();
      rdy = e_ready();
      if (re) begin
        pend = 1'b1;
        pa   = view(rd_addr_a);
        pb   = view(rd_addr_b);
      end else begin
        pend = 1'b0;
      end
      if (we) begin
        e = mq.pop_front();
        if (e.a != '0) file_m[e.a] = e.d;
      end
      if (wr_valid && rdy && wr_addr != '0) begin
        e.a = wr_addr;
        e.d = wr_data;
        mq.push_back(e);
      end
    end
  endtask

  task automatic drive(input bit r, input bit wv, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input bit rv, input logic [AW-1:0] ra, input logic [AW-1:0] rb);
    @(negedge clk);
    rst = r; wr_valid = wv; wr_addr = wa; wr_data = wd;
    rd_valid = rv; rd_addr_a = ra; rd_addr_b = rb;
    if (r) model_reset();
    #1;
    compare_model();
  endtask

  task automatic tick();
    @(posedge clk);
    model_tick();
  endtask

  task automatic step(input bit wv, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                      input bit rv, input logic [AW-1:0] ra, input logic [AW-1:0] rb);
    drive(1'b0, wv, wa, wd, rv, ra, rb);
    tick();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  initial begin
    rst = 1'b1; wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
    rd_valid = 1'b0; rd_addr_a = '0; rd_addr_b = '0;
    pend = 1'b0; pa = '0; pb = '0;

    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 1'b1, 5'd1, 32'h1, 1'b1, 5'd1, 5'd1);
      chk("rst_wq_count", 64'(wq_count), 64'd0);
      chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("rst_wr_ready", 64'(wr_ready), 64'd0);
      chk("rst_rf_re", 64'(rf_re), 64'd0);
      tick();
    end

    // write then drain, then read back through the file
    drive(1'b0, 1'b1, 5'd5, 32'h00001234, 1'b0, '0, '0);
    chk("t1_wr_ready", 64'(wr_ready), 64'd1);
    tick();
    drive(1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
    chk("t1_rf_we", 64'(rf_we), 64'd1);
    chk("t1_rf_reg_w", 64'(rf_reg_w), 64'd5);
    chk("t1_rf_data_in", 64'(rf_data_in), 64'h1234);
    tick();
    step(1'b0, '0, '0, 1'b1, 5'd5, 5'd0);
    drive(1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
    chk("t1_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("t1_rsp_a", 64'(rsp_data_a), 64'h1234);
    tick();

    // youngest queued write wins; source 0 reads as zero
    step(1'b1, 5'd3, 32'hAA, 1'b1, 5'd1, 5'd2);
    step(1'b1, 5'd3, 32'hBB, 1'b1, 5'd1, 5'd2);
    step(1'b0, '0, '0, 1'b1, 5'd3, 5'd0);
    drive(1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
    chk("t2_rsp_a", 64'(rsp_data_a), 64'hBB);
    chk("t2_rsp_b", 64'(rsp_data_b), 64'h0);
    tick();
    idle(3);

    // fill queue under continuous reads
    for (int i = 0; i < D; i++)
      step(1'b1, AW'(10 + i), DW'(32'h100 + i), 1'b1, 5'd10, 5'd11);
    drive(1'b0, 1'b1, 5'd20, 32'h999, 1'b1, 5'd10, 5'd11);
    chk("t3_wq_count", 64'(wq_count), 64'd4);
    chk("t3_wr_ready", 64'(wr_ready), 64'd0);
    chk("t3_rd_ready", 64'(rd_ready), 64'd0);
    chk("t3_rf_we", 64'(rf_we), 64'd1);
    tick();
    drive(1'b0, 1'b1, 5'd20, 32'h999, 1'b1, 5'd10, 5'd11);
    chk("t3_wr_ready_next", 64'(wr_ready), 64'd1);
    tick();
    idle(6);

    // writes to register 0 are accepted and dropped
    drive(1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, '0, '0);
    chk("t4_wr_ready", 64'(wr_ready), 64'd1);
    tick();
    drive(1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
    chk("t4_wq_count", 64'(wq_count), 64'd0);
    chk("t4_rf_we", 64'(rf_we), 64'd0);
    tick();
    step(1'b0, '0, '0, 1'b1, 5'd0, 5'd0);
    drive(1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
    chk("t4_rsp_a", 64'(rsp_data_a), 64'd0);
    tick();

    // asynchronous reset mid-cycle with queued writes and a pending response
    step(1'b1, 5'd1, 32'hA1, 1'b1, 5'd1, 5'd2);
    step(1'b1, 5'd2, 32'hA2, 1'b1, 5'd1, 5'd2);
    step(1'b1, 5'd4, 32'hA4, 1'b1, 5'd2, 5'd4);
    drive(1'b0, 1'b0, '0, '0, 1'b1, 5'd1, 5'd2);
    chk("t5_pre_count", 64'(wq_count), 64'd3);
    chk("t5_pre_rsp", 64'(rsp_valid), 64'd1);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    chk("t5_wq_count", 64'(wq_count), 64'd0);
    chk("t5_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("t5_rf_we", 64'(rf_we), 64'd0);
    tick();
    drive(1'b1, 1'b0, '0, '0, 1'b0, '0, '0);
    tick();
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
      chk("t5_no_we", 64'(rf_we), 64'd0);
      tick();
    end

    // same-edge write and read: read sees the older value
    step(1'b1, 5'd7, 32'h11, 1'b0, '0, '0);
    idle(2);
    step(1'b1, 5'd7, 32'h55, 1'b1, 5'd7, 5'd0);
    drive(1'b0, 1'b0, '0, '0, 1'b1, 5'd7, 5'd7);
    chk("t6_rsp_a_old", 64'(rsp_data_a), 64'h11);
    tick();
    drive(1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
    chk("t6_rsp_a_new", 64'(rsp_data_a), 64'h55);
    chk("t6_rsp_b_new", 64'(rsp_data_b), 64'h55);
    tick();

    // randomized traffic with varying read pressure
    for (int ph = 0; ph < 3; ph++) begin
      int bias;
      bias = (ph == 0) ? 30 : (ph == 1) ? 75 : 97;
      for (int k = 0; k < 1000; k++) begin
        drive(($urandom_range(0, 299) == 0),
              ($urandom_range(0, 3) != 0), AW'($urandom_range(0, 7)), DW'($urandom),
              ($urandom_range(0, 99) < bias),
              AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)));
        tick();
      end
    end
    idle(10);

    for (int i = 1; i < 32; i++) chk("rf_final", 64'(rf_mem[i]), 64'(file_m[i]));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
